// File: rtl/mc_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one ALU, one register file and one extender
// shared across FETCH/DECODE/EXEC/MEM/WB, with handshaked external memories.
module mc_cycle_cpu #(
  parameter logic [31:0] RESET_PC        = 32'h0000_3000,
  parameter int unsigned TIMEOUT         = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [31:0] instret
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW  = 6'h23,
                         OP_SW    = 6'h2B;

  localparam logic [1:0] ERR_ILLEGAL = 2'd1, ERR_TIMEOUT = 2'd2, ERR_ALIGN = 2'd3;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

  state_t      state;
  logic [31:0] pc, ir, a_reg, b_reg, imm32, alu_out, mdr;
  logic [7:0]  wait_cnt;
  logic [31:0] gpr [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_dest;
  logic [31:0] rs_val, rt_val, wb_data, alu_res;
  kind_t       kind;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];

  // r0 is hardwired to zero on the read side; writes to it are dropped in WB.
  assign rs_val  = (rs == 5'd0) ? '0 : gpr[rs];
  assign rt_val  = (rt == 5'd0) ? '0 : gpr[rt];
  assign wb_dest = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data = (opcode == OP_LW) ? mdr : alu_out;

  assign imem_req   = (state == S_FETCH) && !reset;
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM) && !reset;
  assign dmem_we    = dmem_req && (opcode == OP_SW);
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b_reg;

  always_comb begin
    kind    = K_ILL;
    alu_res = '0;
    case (opcode)
      OP_RTYPE: begin
        kind = K_ALU;
        case (funct)
          6'h20, 6'h21: alu_res = a_reg + b_reg;
          6'h23:        alu_res = a_reg - b_reg;
          6'h24:        alu_res = a_reg & b_reg;
          6'h25:        alu_res = a_reg | b_reg;
          6'h2A:        alu_res = {31'd0, $signed(a_reg) < $signed(b_reg)};
          default:      kind    = K_ILL;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin kind = K_ALU; alu_res = a_reg + imm32; end
      OP_ANDI:           begin kind = K_ALU; alu_res = a_reg & imm32; end
      OP_ORI:            begin kind = K_ALU; alu_res = a_reg | imm32; end
      OP_LUI:            begin kind = K_ALU; alu_res = {ir[15:0], 16'd0}; end
      OP_LW:             begin kind = K_LW;  alu_res = a_reg + imm32; end
      OP_SW:             begin kind = K_SW;  alu_res = a_reg + imm32; end
      OP_BEQ:            kind = K_BEQ;
      OP_J:              kind = K_J;
      default:           kind = K_ILL;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      imm32    <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      wait_cnt <= '0;
      instret  <= '0;
      halted   <= 1'b0;
      err_code <= '0;
    end else begin
      // Counter only survives inside FETCH/MEM; any other state clears it.
      wait_cnt <= '0;
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir    <= imem_rdata;
            pc    <= pc + 32'd4;
            state <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= S_HALT;
            halted   <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          a_reg <= rs_val;
          b_reg <= rt_val;
          imm32 <= (opcode == OP_ANDI || opcode == OP_ORI) ? {16'd0, ir[15:0]}
                                                           : {{16{ir[15]}}, ir[15:0]};
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          case (kind)
            K_ALU: state <= S_WB;
            K_LW, K_SW: begin
              if (alu_res[1:0] != 2'b00) begin
                state    <= S_HALT;
                halted   <= 1'b1;
                err_code <= ERR_ALIGN;
              end else begin
                state <= S_MEM;
              end
            end
            K_BEQ, K_J: begin
              if (kind == K_J)
                pc <= {pc[31:28], ir[25:0], 2'b00};
              else if (a_reg == b_reg)
                pc <= pc + {imm32[29:0], 2'b00};
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end
            default: begin
              if (HALT_ON_ILLEGAL) begin
                state    <= S_HALT;
                halted   <= 1'b1;
                err_code <= ERR_ILLEGAL;
              end else begin
                instret <= instret + 32'd1;
                state   <= S_FETCH;
              end
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (opcode == OP_SW) begin
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end else begin
              mdr   <= dmem_rdata;
              state <= S_WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= S_HALT;
            halted   <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          instret <= instret + 32'd1;
          state   <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // NOTE: the register file is deliberately not reset; software must write a
  // register before reading it, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (!reset && state == S_WB && wb_dest != 5'd0)
      gpr[wb_dest] <= wb_data;
  end

endmodule
